// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Holds datapath widths and the requester index assignment.
package wb_arbiter_pkg;
    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;
    localparam int REQ_ALU  = 0;
    localparam int REQ_LSU  = 1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a combinational grant.
// The pointer remembers the last winner and moves only when a grant is issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import wb_arbiter_pkg::*;

    // last_q = 1 when LSU won most recently; reset value makes LSU win the first tie
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            if (req == 2'b11) begin
                if (last_q) begin
                    gnt[REQ_ALU] = 1'b1;
                end else begin
                    gnt[REQ_LSU] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt[REQ_LSU]) begin
            last_d = 1'b1;
        end else if (gnt[REQ_ALU]) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results onto the register-file write port
// and tracks registers with outstanding writes for operand hazard checks.
module wb_arbiter #(
    parameter int XLEN = wb_arbiter_pkg::XLEN,
    parameter int AW   = wb_arbiter_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_addr,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_addr,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_we,
    output logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_wdata
);
    import wb_arbiter_pkg::*;

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                xfer;
    logic [AW-1:0]       sel_addr;
    logic [XLEN-1:0]     sel_data;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                rd_we_q, rd_we_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]     rd_wdata_q, rd_wdata_d;

    always_comb begin
        req          = 2'b00;
        req[REQ_ALU] = alu_valid;
        req[REQ_LSU] = lsu_valid;
    end

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign lsu_ready = gnt[REQ_LSU];
    assign xfer      = |gnt;
    assign sel_addr  = gnt[REQ_LSU] ? lsu_addr : alu_addr;
    assign sel_data  = gnt[REQ_LSU] ? lsu_data : alu_data;

    // Hazard lookup reads the pre-edge scoreboard, so no bypass of this cycle's set/clear
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];

    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (iss_valid) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rd_we_d    = xfer && (sel_addr != '0);
        rd_addr_d  = rd_addr_q;
        rd_wdata_d = rd_wdata_q;
        if (xfer) begin
            rd_addr_d  = sel_addr;
            rd_wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_wdata_q <= '0;
        end else begin
            busy_q     <= busy_d;
            rd_we_q    <= rd_we_d;
            rd_addr_q  <= rd_addr_d;
            rd_wdata_q <= rd_wdata_d;
        end
    end

    assign rd_we    = rd_we_q;
    assign rd_addr  = rd_addr_q;
    assign rd_wdata = rd_wdata_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a reference model predicts grants and
// scoreboard state, expected register-file writes are queued and compared a cycle later.
module tb_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 1'b0;
    logic [AW-1:0]   alu_addr  = '0;
    logic [XLEN-1:0] alu_data  = '0;
    logic            alu_ready;
    logic            lsu_valid = 1'b0;
    logic [AW-1:0]   lsu_addr  = '0;
    logic [XLEN-1:0] lsu_data  = '0;
    logic            lsu_ready;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_addr  = '0;
    logic [AW-1:0]   rs1_addr  = '0;
    logic [AW-1:0]   rs2_addr  = '0;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_wdata;

    wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_we     (rd_we),
        .rd_addr   (rd_addr),
        .rd_wdata  (rd_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        m_last   = 1'b0;  // 1 = LSU won last contested-or-not grant
    logic [31:0] m_busy   = '0;
    logic        m_ag     = 1'b0;
    logic        m_lg     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act === req_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, req_v, $time);
        end
    endtask

    // One clock: check combinational outputs mid-cycle, model the edge, check registered outputs after it
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        m_ag = 1'b0;
        m_lg = 1'b0;
        if (rst) begin
            if (alu_valid && lsu_valid) begin
                if (m_last) m_ag = 1'b1;
                else        m_lg = 1'b1;
            end else begin
                m_ag = alu_valid;
                m_lg = lsu_valid;
            end
        end
        chk("alu_ready", 32'(alu_ready), 32'(m_ag));
        chk("lsu_ready", 32'(lsu_ready), 32'(m_lg));
        chk("rs1_busy", 32'(rs1_busy), 32'(m_busy[rs1_addr]));
        chk("rs2_busy", 32'(rs2_busy), 32'(m_busy[rs2_addr]));
        e.we   = 1'b0;
        e.addr = '0;
        e.data = '0;
        if (m_ag) begin
            e.addr = alu_addr;
            e.data = alu_data;
        end
        if (m_lg) begin
            e.addr = lsu_addr;
            e.data = lsu_data;
        end
        if (m_ag || m_lg) begin
            e.we   = (e.addr != '0);
            m_last = m_lg;
            if (e.addr != '0) m_busy[e.addr] = 1'b0;
        end
        if (rst && iss_valid && iss_addr != '0) m_busy[iss_addr] = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("rd_we", 32'(rd_we), 32'(e.we));
        if (e.we) begin
            chk("rd_addr", 32'(rd_addr), 32'(e.addr));
            chk("rd_wdata", rd_wdata, e.data);
        end
    endtask

    always @(negedge clk) begin
        chk("rdy_onehot", 32'(alu_ready & lsu_ready), 32'd0);
        chk("alu_rdy_no_vld", 32'(alu_ready & ~alu_valid), 32'd0);
        chk("lsu_rdy_no_vld", 32'(lsu_ready & ~lsu_valid), 32'd0);
        chk("we_x0", 32'(rd_we && rd_addr == '0), 32'd0);
    end

    initial begin
        logic [AW-1:0] ord [4];
        ord[0] = AW'(7); ord[1] = AW'(3); ord[2] = AW'(7); ord[3] = AW'(3);

        #1;
        chk("rst_rd_we", 32'(rd_we), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_rd_wdata", rd_wdata, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        alu_valid = 1'b1;
        alu_addr  = AW'(4);
        cycle();
        alu_valid = 1'b0;
        rst = 1'b1;

        // Contention straight after reset: LSU wins first, then alternation
        alu_valid = 1'b1; alu_addr = AW'(3); alu_data = 32'h0000_0333;
        lsu_valid = 1'b1; lsu_addr = AW'(7); lsu_data = 32'h0000_0777;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("contend_addr", 32'(rd_addr), 32'(ord[i]));
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        cycle();

        alu_valid = 1'b1; alu_addr = AW'(5); alu_data = 32'hABCD_ABCD;
        cycle();
        chk("alu_only_we", 32'(rd_we), 32'd1);
        chk("alu_only_addr", 32'(rd_addr), 32'd5);
        chk("alu_only_data", rd_wdata, 32'hABCD_ABCD);
        alu_valid = 1'b0;
        cycle();

        lsu_valid = 1'b1; lsu_addr = '0; lsu_data = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_addr = '0; rs1_addr = '0;
        cycle();
        chk("x0_we", 32'(rd_we), 32'd0);
        chk("x0_busy", 32'(rs1_busy), 32'd0);
        lsu_valid = 1'b0;

        iss_valid = 1'b1; iss_addr = AW'(10); rs1_addr = AW'(10); rs2_addr = AW'(11);
        cycle();
        chk("sb_set", 32'(rs1_busy), 32'd1);
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = AW'(10); alu_data = 32'h1010_1010;
        cycle();
        chk("sb_clear", 32'(rs1_busy), 32'd0);
        alu_valid = 1'b0;
        iss_valid = 1'b1;
        cycle();
        alu_valid = 1'b1;
        cycle();
        chk("sb_set_wins", 32'(rs1_busy), 32'd1);
        alu_valid = 1'b0;
        iss_valid = 1'b0;
        cycle();

        for (int i = 0; i < 150; i++) begin
            if (!alu_valid || m_ag) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_addr  = AW'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!lsu_valid || m_lg) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_addr  = AW'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_addr  = AW'($urandom_range(0, 31));
            rs1_addr  = AW'($urandom_range(0, 31));
            rs2_addr  = AW'($urandom_range(0, 31));
            cycle();
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        iss_valid = 1'b0;
        cycle();

        // Asynchronous reset while a request is pending and registers are busy
        iss_valid = 1'b1; iss_addr = AW'(12);
        cycle();
        iss_addr = AW'(13); rs1_addr = AW'(12);
        alu_valid = 1'b1; alu_addr = AW'(8); alu_data = 32'h8888_8888;
        cycle();
        iss_valid = 1'b0;
        chk("pre_rst_we", 32'(rd_we), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_rd_we", 32'(rd_we), 32'd0);
        chk("arst_rd_addr", 32'(rd_addr), 32'd0);
        chk("arst_rd_wdata", rd_wdata, 32'd0);
        chk("arst_alu_ready", 32'(alu_ready), 32'd0);
        chk("arst_busy12", 32'(rs1_busy), 32'd0);
        m_busy = '0;
        m_last = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            rs2_addr = AW'(i);
            #1;
            chk("arst_busy", 32'(rs2_busy), 32'd0);
        end
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("post_rst_addr", 32'(rd_addr), 32'd8);
        alu_valid = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of a register-file write.
REQ-002 Parameter AW, default 5, register address width (32 registers).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 alu_valid  input  1  ALU write-back request.
REQ-006 alu_addr  input  AW  ALU destination register.
REQ-007 alu_data  input  XLEN  ALU write data.
REQ-008 alu_ready  output  1  ALU request accepted this cycle.
REQ-009 lsu_valid / lsu_addr / lsu_data / lsu_ready: same widths and meaning as REQ-005..008, load unit.
REQ-010 iss_valid  input  1  issue stage marks a destination pending.
REQ-011 iss_addr  input  AW  destination register being issued.
REQ-012 rs1_addr, rs2_addr  input  AW  operands to check for pending writes.
REQ-013 rs1_busy, rs2_busy  output  1  operand has an outstanding write (combinational on addr and scoreboard).
REQ-014 rd_we  output  1  register-file write enable (registered).
REQ-015 rd_addr  output  AW  register-file write address (registered).
REQ-016 rd_wdata  output  XLEN  register-file write data (registered).

Function
REQ-017 A transfer occurs on a requester when valid and ready are both 1 at a rising edge.
REQ-018 At most one of alu_ready/lsu_ready SHALL be 1 per cycle; ready SHALL be 0 when its valid is 0.
REQ-019 Sole valid requester SHALL receive ready in the same cycle (combinational grant, no idle bubble).
REQ-020 Both valid: grant SHALL go to the requester not granted last; pointer updates only on a transfer.
REQ-021 Pointer after reset SHALL favour LSU (first contested grant goes to LSU).
REQ-022 Transfer in cycle N SHALL drive rd_we=1, rd_addr, rd_wdata in cycle N+1 only; rd_we=0 in cycles with no transfer.
REQ-023 Transfer with addr 0 SHALL be accepted (ready=1) but SHALL produce rd_we=0 in N+1.
REQ-024 Requesters hold valid/addr/data stable until ready; arbiter does not buffer unaccepted requests.
REQ-025 Scoreboard: 32 busy bits; iss_valid sets busy[iss_addr] at the edge; a transfer clears busy[addr] at the edge.
REQ-026 Simultaneous set and clear of the same register SHALL leave it busy (set wins).
REQ-027 busy[0] SHALL always read 0; iss_addr 0 is ignored.
REQ-028 rsX_busy SHALL reflect scoreboard state before the current edge (no same-cycle bypass of set or clear).
REQ-029 Transfer to a non-busy register SHALL still write; busy bit stays 0.

Reset
REQ-030 rst=0 SHALL immediately force rd_we=0, rd_addr=0, rd_wdata=0, all busy bits 0, pointer to LSU-first.
REQ-031 alu_ready/lsu_ready SHALL be 0 while rst=0; a request in flight at reset is dropped, not written.
REQ-032 Deassertion of rst takes effect at the next rising edge; no transfer completes in the deassertion cycle if rst is released after the edge.

Structure
REQ-033 Shared package holds XLEN, AW, NUM_REGS=32, requester index constants REQ_ALU=0, REQ_LSU=1.
REQ-034 Two-way round-robin grant logic SHALL be a sub-module rr_arb2 (req[1:0] in, gnt[1:0] out, pointer inside).
REQ-035 Scoreboard and output registers live in wb_arbiter; outputs connect directly to the 32x32 register file write port.

Verification
REQ-036 ALU only: alu_valid, addr 5, data 0xABCD_ABCD -> alu_ready same cycle; next cycle rd_we=1, rd_addr=5, rd_wdata=0xABCD_ABCD.
REQ-037 Contention: both valid 4 cycles (ALU addr 3, LSU addr 7) after reset -> grants LSU, ALU, LSU, ALU; rd_addr 7,3,7,3.
REQ-038 x0 write: lsu addr 0, data 0xFFFF_FFFF -> lsu_ready=1, rd_we stays 0; busy[0] reads 0.
REQ-039 Scoreboard: iss 10, then rs1_addr=10 -> rs1_busy=1; ALU write addr 10 -> rs1_busy=0 cycle after transfer; iss 10 and transfer 10 same edge -> stays 1.
REQ-040 Reset mid-stream: rst=0 asynchronously while ALU valid addr 8 -> rd_we=0, ready=0, all busy 0 without waiting for a clock edge.
REQ-041 Bench SHALL assert ready one-hot and rd_we never set for addr 0 on every cycle.
